// File: rtl/rotator_rr_arbiter.sv
// Purpose: round-robin shares one 8-bit rotate-right datapath among NUM_REQ requesters.
// Latency: request accepted in cycle N gives a registered result from cycle N+1.
// Backpressure: one-entry output stage; req_ready drops while a result is stalled.

// Three-stage rotate-right of a byte by 0..7 positions.
module barrel_shifter (
  input  logic [7:0] data_i,
  input  logic [2:0] amt_i,
  output logic [7:0] data_o
);
  logic [7:0] stg1;
  logic [7:0] stg2;

  // Each stage rotates by a power of two, selected by one amount bit.
  always_comb begin
    stg1   = amt_i[0] ? {data_i[0],   data_i[7:1]} : data_i;
    stg2   = amt_i[1] ? {stg1[1:0],   stg1[7:2]}   : stg1;
    data_o = amt_i[2] ? {stg2[3:0],   stg2[7:4]}   : stg2;
  end
endmodule

module rotator_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [3*NUM_REQ-1:0] req_sh_amt,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_ready
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            can_accept;
  logic            xfer;
  logic [7:0]      sel_data;
  logic [2:0]      sel_amt;
  logic [7:0]      rot_data;
  logic            rsp_valid_q;
  logic [7:0]      rsp_data_q;
  logic [ID_W-1:0] rsp_id_q;
  int              idx;

  // Round-robin search from ptr; scanning offsets high-to-low lets the
  // nearest valid requester overwrite any farther one.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  // Accept when the output stage is empty or draining; grant strobe is one-hot.
  always_comb begin
    can_accept = !rsp_valid_q || rsp_ready;
    xfer       = gnt_any && can_accept && !rst;
    req_ready  = '0;
    if (xfer) begin
      req_ready[gnt_idx] = 1'b1;
    end
    sel_data = req_data[8*int'(gnt_idx) +: 8];
    sel_amt  = req_sh_amt[3*int'(gnt_idx) +: 3];
    // Explicit wrap keeps ptr below NUM_REQ for non-power-of-two counts.
    ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  barrel_shifter u_rot (
    .data_i (sel_data),
    .amt_i  (sel_amt),
    .data_o (rot_data)
  );

  // Output stage and pointer: load on transfer, drain on rsp_ready, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rot_data;
      rsp_id_q    <= gnt_idx;
      ptr_q       <= ptr_d;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_rotator_rr_arbiter.sv
// Purpose: directed self-checking bench for rotator_rr_arbiter with NUM_REQ=4.
// Latency: checks grant in the request cycle and the result one edge later.
// Backpressure: holds rsp_ready low to confirm stall and stable outputs.
module tb_rotator_rr_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [11:0] req_sh_amt;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;

  int n_cmp;
  int n_err;

  logic [7:0] sweep_exp [8] = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
  logic [7:0] fair_exp  [4] = '{8'h01, 8'h80, 8'h40, 8'h20};

  rotator_rr_arbiter #(.NUM_REQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_sh_amt (req_sh_amt),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] a);
    req_data[8*i +: 8]   = d;
    req_sh_amt[3*i +: 3] = a;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b0;
    req_valid  = 4'b1111;
    req_data   = '0;
    req_sh_amt = '0;
    rsp_ready  = 1'b0;
    #1 rst = 1'b1;
    #2;
    // Reset state: outputs cleared, no grant even with all requesters valid.
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_data",  32'(rsp_data),  32'h00);
    chk("rst_id",    32'(rsp_id),    32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    req_valid = 4'b0000;
    tick();
    tick();
    rst = 1'b0;

    // 1. Single requester 2: B4 ror 3 = 96.
    rsp_ready = 1'b1;
    set_req(2, 8'hB4, 3'd3);
    req_valid = 4'b0100;
    #1 chk("t1_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_data",  32'(rsp_data),  32'h96);
    chk("t1_id",    32'(rsp_id),    32'h2);
    tick();
    chk("t1_drain", 32'(rsp_valid), 32'h0);
    chk("t1_hold",  32'(rsp_data),  32'h96);

    // 2. Rotate sweep on requester 0, back-to-back.
    req_valid = 4'b0001;
    for (int s = 0; s < 8; s++) begin
      set_req(0, 8'h81, 3'(s));
      #1 chk("t2_ready", 32'(req_ready), 32'h1);
      tick();
      chk("t2_valid", 32'(rsp_valid), 32'h1);
      chk("t2_data",  32'(rsp_data),  32'(sweep_exp[s]));
    end

    // ptr is 1 here; a lone grant to requester 3 wraps it to 0.
    req_valid = 4'b1000;
    set_req(3, 8'h01, 3'd3);
    #1 chk("wrap_ready", 32'(req_ready), 32'h8);
    tick();
    chk("wrap_id", 32'(rsp_id), 32'h3);

    // 3. Fairness: all valid, rsp_ready=1, eight transfers.
    for (int i = 0; i < 4; i++) set_req(i, 8'h01, 3'(i));
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      #1 chk("t3_ready", 32'(req_ready), 32'(4'b0001 << (n % 4)));
      tick();
      chk("t3_id",   32'(rsp_id),   32'(n % 4));
      chk("t3_data", 32'(rsp_data), 32'(fair_exp[n % 4]));
    end

    // 4. Skip and wrap: grant 2 alone so ptr=3, then only 1 and 3 valid.
    req_valid = 4'b0100;
    tick();
    chk("t4_pre_id", 32'(rsp_id), 32'h2);
    req_valid = 4'b1010;
    #1 chk("t4_ready_a", 32'(req_ready), 32'h8);
    tick();
    chk("t4_id_a", 32'(rsp_id), 32'h3);
    chk("t4_ready_b", 32'(req_ready), 32'h2);
    tick();
    chk("t4_id_b", 32'(rsp_id), 32'h1);
    chk("t4_ready_c", 32'(req_ready), 32'h8);
    tick();
    chk("t4_id_c", 32'(rsp_id), 32'h3);
    req_valid = 4'b0000;
    tick();
    chk("t4_drain", 32'(rsp_valid), 32'h0);

    // 5. Backpressure: load 5A ror 4 = A5 into the stage, then stall.
    rsp_ready = 1'b0;
    set_req(0, 8'h5A, 3'd4);
    req_valid = 4'b0001;
    #1 chk("t5_load_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t5_load_data", 32'(rsp_data), 32'hA5);
    req_valid = 4'b0010;
    set_req(1, 8'hFF, 3'd5);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) set_req(1, 8'h3C, 3'd1);
      #1 chk("t5_stall_ready", 32'(req_ready), 32'h0);
      tick();
      chk("t5_stall_valid", 32'(rsp_valid), 32'h1);
      chk("t5_stall_data",  32'(rsp_data),  32'hA5);
      chk("t5_stall_id",    32'(rsp_id),    32'h0);
    end
    rsp_ready = 1'b1;
    #1 chk("t5_release_ready", 32'(req_ready), 32'h2);
    tick();
    chk("t5_new_data", 32'(rsp_data), 32'h1E);
    chk("t5_new_id",   32'(rsp_id),   32'h1);

    // 6. Reset mid-operation with a stalled result pending.
    rsp_ready = 1'b0;
    req_valid = 4'b1001;
    set_req(0, 8'h0F, 3'd0);
    set_req(3, 8'hC3, 3'd2);
    #2;
    chk("t6_pending", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 32'h0);
    chk("t6_rst_data",  32'(rsp_data),  32'h00);
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("t6_ready_a", 32'(req_ready), 32'h1);
    tick();
    chk("t6_id_a",   32'(rsp_id),   32'h0);
    chk("t6_data_a", 32'(rsp_data), 32'h0F);
    chk("t6_ready_b", 32'(req_ready), 32'h8);
    tick();
    chk("t6_id_b",   32'(rsp_id),   32'h3);
    chk("t6_data_b", 32'(rsp_data), 32'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
